data_mem_responder: RTL and testbench

Memory-side responder for the core's load/store port. It accepts one word-sized read or write request at a time through a valid/ready handshake and applies a configurable number of wait states. It then performs the access on an internal byte-addressed store and returns read data or an error through a second valid/ready handshake. It replaces the zero-latency data memory when the pipeline is exercised against a slow target.

---
 rtl/data_mem_responder.sv | 142 ++++++++++++++
 tb/tb_data_mem_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Load/store memory responder: one outstanding word access, programmable wait states,
// byte-addressed internal store, registered valid/ready request and response handshakes.
module data_mem_responder #(
   parameter int unsigned ADDRESS_WIDTH = 8,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned WAIT_CYCLES   = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic [ADDRESS_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0]    req_wdata,
   input  logic [3:0]               req_be,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [DATA_WIDTH-1:0]    rsp_rdata,
   output logic                     rsp_err
);

   localparam int unsigned WORD_AW = ADDRESS_WIDTH - 2;
   localparam int unsigned WORDS   = 1 << WORD_AW;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned BE_W    = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_e;

   typedef struct packed {
      logic                     we;
      logic [ADDRESS_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0]    wdata;
      logic [BE_W-1:0]          be;
   } req_t;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   req_t                    req_q, req_d;
   logic                    req_ready_q, req_ready_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                    rsp_err_q, rsp_err_d;

   logic [DATA_WIDTH-1:0]   mem_q [WORDS];
   logic                    mem_we_c;
   logic                    aligned_c;
   logic [WORD_AW-1:0]      word_idx_c;

   assign aligned_c  = (req_q.addr[1:0] == 2'b00);
   assign word_idx_c = req_q.addr[ADDRESS_WIDTH-1:2];

   // WAIT runs the counter down to zero, so the response lands WAIT_CYCLES+1 edges after accept.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      req_d       = req_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      mem_we_c    = 1'b0;

      case (state_q)
         S_IDLE: begin
            req_ready_d = 1'b1;
            if (req_valid && req_ready_q) begin
               req_d.we    = req_we;
               req_d.addr  = req_addr;
               req_d.wdata = req_wdata;
               req_d.be    = req_be;
               cnt_d       = CNT_W'(WAIT_CYCLES);
               req_ready_d = 1'b0;
               state_d     = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = ~aligned_c;
               mem_we_c    = req_q.we & aligned_c;
               rsp_rdata_d = (aligned_c && !req_q.we) ? mem_q[word_idx_c] : '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b0;
               req_ready_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         req_q       <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_q       <= req_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Storage is deliberately not reset; contents survive rst.
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         for (int i = 0; i < BE_W; i++) begin
            if (req_q.be[i]) begin
               mem_q[word_idx_c][8*i +: 8] <= req_q.wdata[8*i +: 8];
            end
         end
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed load/store vectors, latency,
// backpressure and reset-abandon cases, plus a zero-wait-state instance.
module tb_data_mem_responder;

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 32;
   localparam int unsigned WC = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready, req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [3:0]    req_be;
   logic          rsp_valid, rsp_ready, rsp_err;
   logic [DW-1:0] rsp_rdata;

   logic          req_valid0, req_ready0, req_we0;
   logic [AW-1:0] req_addr0;
   logic [DW-1:0] req_wdata0;
   logic [3:0]    req_be0;
   logic          rsp_valid0, rsp_ready0, rsp_err0;
   logic [DW-1:0] rsp_rdata0;

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   acc;
   int   h;

   data_mem_responder #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(WC)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   data_mem_responder #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
      .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0),
      .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
      .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the expected response at each response handshake.
   always @(negedge clk) begin
      #2;
      if (rst && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_underflow: got unexpected response rdata 0x%08h err %0b", rsp_rdata, rsp_err);
         end else begin
            mon_e = sb.pop_front();
            chk("rsp_rdata", rsp_rdata, mon_e.rdata);
            chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
         end
      end
   end

   // Issue one request from a falling edge; returns at the falling edge after accept
   // or, when wait_rsp is set, at the first falling edge with rsp_valid high.
   task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input logic [3:0] be, input logic [DW-1:0] e_rdata, input logic e_err,
                       input bit wait_rsp, output int acc_cyc);
      int t;
      exp_t e;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_be    = be;
      t = 0;
      while (!req_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("accept_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      acc_cyc   = cyc;
      req_valid = 1'b0;
      e.rdata   = e_rdata;
      e.err     = e_err;
      sb.push_back(e);
      if (wait_rsp) begin
         t = 0;
         while (!rsp_valid && t < 50) begin
            @(negedge clk);
            t++;
         end
         chk("latency", 32'(cyc - acc_cyc), 32'(WC + 1));
      end
   endtask

   // Wait for the response handshake and check the idle state that follows it.
   task automatic drain();
      int t;
      t = 0;
      while (rsp_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("post_rsp_rdata", rsp_rdata, 32'd0);
      chk("post_rsp_err", 32'(rsp_err), 32'd0);
      chk("post_req_ready", 32'(req_ready), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
      chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b0;
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_addr   = 8'h10;
      req_wdata  = '0;
      req_be     = 4'h0;
      rsp_ready  = 1'b1;
      req_valid0 = 1'b0;
      req_we0    = 1'b0;
      req_addr0  = '0;
      req_wdata0 = '0;
      req_be0    = 4'h0;
      rsp_ready0 = 1'b0;

      // Reset held with a request pending; release must not cause an accept.
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rst = 1'b1;
      @(negedge clk);
      chk("rel_req_ready", 32'(req_ready), 32'd1);
      chk("rel_rsp_valid", 32'(rsp_valid), 32'd0);
      req_valid = 1'b0;
      @(negedge clk);
      chk("rel_no_accept", 32'(req_ready), 32'd1);

      // Full write, read back.
      send(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1'b1, acc); drain();
      send(1'b0, 8'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1, acc); drain();

      // Partial byte-enable write, then be = 0 write.
      send(1'b1, 8'h10, 32'h11223344, 4'b0101, 32'h0, 1'b0, 1'b1, acc); drain();
      send(1'b0, 8'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, 1'b1, acc); drain();
      send(1'b1, 8'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 1'b1, acc); drain();
      send(1'b0, 8'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, 1'b1, acc); drain();

      // Misaligned accesses return an error and leave the store alone.
      send(1'b0, 8'h13, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, acc); drain();
      send(1'b1, 8'h12, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1, acc); drain();
      send(1'b0, 8'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, 1'b1, acc); drain();

      // Backpressure with a second request waiting.
      rsp_ready = 1'b0;
      send(1'b0, 8'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, 1'b1, acc);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 8'h10;
      req_wdata = '0;
      req_be    = 4'h0;
      repeat (5) begin
         @(negedge clk);
         chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_rsp_rdata", rsp_rdata, 32'hDE22BE44);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      h = cyc + 1;
      @(negedge clk);
      chk("bp_h_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("bp_h_req_ready", 32'(req_ready), 32'd1);
      send(1'b0, 8'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, 1'b1, acc);
      chk("bp_accept_edge", 32'(acc), 32'(h + 1));
      drain();

      // Zero wait states: response one edge after accept.
      chk("w0_req_ready", 32'(req_ready0), 32'd1);
      req_valid0 = 1'b1;
      req_addr0  = 8'h01;
      @(negedge clk);
      req_valid0 = 1'b0;
      chk("w0_lat_early", 32'(rsp_valid0), 32'd0);
      chk("w0_req_ready_low", 32'(req_ready0), 32'd0);
      @(negedge clk);
      chk("w0_rsp_valid", 32'(rsp_valid0), 32'd1);
      chk("w0_rsp_err", 32'(rsp_err0), 32'd1);
      chk("w0_rsp_rdata", rsp_rdata0, 32'd0);
      rsp_ready0 = 1'b1;
      @(negedge clk);
      chk("w0_post_valid", 32'(rsp_valid0), 32'd0);

      // Reset during WAIT abandons the write.
      send(1'b1, 8'h20, 32'h0, 4'hF, 32'h0, 1'b0, 1'b1, acc); drain();
      send(1'b1, 8'h20, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 1'b0, acc);
      rst = 1'b0;
      #1;
      check_reset_outputs("rst_wait");
      sb.delete();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      send(1'b0, 8'h20, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, acc); drain();

      // Reset during RESP keeps the completed write.
      rsp_ready = 1'b0;
      send(1'b1, 8'h24, 32'h12345678, 4'hF, 32'h0, 1'b0, 1'b1, acc);
      rst = 1'b0;
      #1;
      check_reset_outputs("rst_resp");
      sb.delete();
      rsp_ready = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      send(1'b0, 8'h24, 32'h0, 4'h0, 32'h12345678, 1'b0, 1'b1, acc); drain();

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
